// File: rtl/gatenet_vote_classifier.sv
// -----------------------------------------------------------------------------
// gatenet_vote_classifier
//
// Purpose:
//   Turns the raw output bits of a logic-gate network into a class decision.
//   Every class owns GROUP vote bits. The class score is the popcount of those
//   bits. The block accepts one vote vector and scores one class per cycle
//   with a single shared popcount unit. It then presents:
//     - the winning class,
//     - its score,
//     - the margin over the runner-up,
//     - a tie flag.
//   Ties resolve toward the lowest class index.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   vote vector valid
//   in_ready    out  block idle and able to accept a vote vector
//   in_votes    in   N_CLASS*GROUP vote bits; class c owns [c*GROUP +: GROUP]
//   out_valid   out  result valid (held until out_ready)
//   out_ready   in   consumer takes the result
//   out_class   out  index of the winning class
//   out_score   out  popcount of the winning class (0..GROUP)
//   out_margin  out  winning score minus runner-up score
//   out_tie     out  another class matches the winning score
//
// Throughput is one vector every N_CLASS+2 cycles. Accept, scan and result
// phases never overlap. Every output is decoded from registers only.
// -----------------------------------------------------------------------------
module gatenet_vote_classifier #(
  parameter int N_CLASS = 2,
  parameter int GROUP   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [N_CLASS*GROUP-1:0]                  in_votes,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [(($clog2(N_CLASS) > 1) ? $clog2(N_CLASS) : 1)-1:0] out_class,
  output logic [$clog2(GROUP+1)-1:0]                out_score,
  output logic [$clog2(GROUP+1)-1:0]                out_margin,
  output logic                                      out_tie
);

  localparam int SCORE_W = $clog2(GROUP + 1);
  localparam int IDX_W   = ($clog2(N_CLASS) > 1) ? $clog2(N_CLASS) : 1;
  localparam int VOTE_W  = N_CLASS * GROUP;
  localparam logic [IDX_W-1:0] LAST_CLS = IDX_W'(N_CLASS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic                 r_live;     // low from reset until the first clock edge
  logic [VOTE_W-1:0]    r_votes;
  logic [IDX_W-1:0]     r_cls;
  logic [IDX_W-1:0]     r_idx;
  logic [SCORE_W-1:0]   r_best;
  logic [SCORE_W-1:0]   r_second;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [VOTE_W-1:0]    w_shifted;
  logic [GROUP-1:0]     w_group;
  logic [SCORE_W-1:0]   w_score;

  // in_ready stays low through reset and until the first edge after release.
  // The state alone would already read IDLE during reset, so r_live gates it.
  assign w_in_ready = r_live && (r_state == S_IDLE);
  assign w_accept   = in_valid && w_in_ready;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking (<=) assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment comes first so that every path through the
  // case drives w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept)            w_next_state = S_SCAN;
      S_SCAN: if (r_cls == LAST_CLS)   w_next_state = S_DONE;
      S_DONE: if (out_ready)           w_next_state = S_IDLE;
      default:                         w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared popcount unit: selects class r_cls from the registered vector
  // ---------------------------------------------------------------------------
  always_comb begin
    w_shifted = r_votes >> (int'(r_cls) * GROUP);
    w_group   = w_shifted[GROUP-1:0];
    w_score   = '0;
    for (int i = 0; i < GROUP; i++) begin
      w_score = w_score + SCORE_W'(w_group[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: vote capture, class counter, best / runner-up tracking
  // ---------------------------------------------------------------------------
  // NOTE: the vote register is reset explicitly. A sample abandoned by reset
  // therefore leaves no residue, and the reset state is fully defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_votes  <= '0;
      r_cls    <= '0;
      r_idx    <= '0;
      r_best   <= '0;
      r_second <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_votes  <= in_votes;
            r_cls    <= '0;
            r_best   <= '0;
            r_second <= '0;
          end
        end
        S_SCAN: begin
          // Only a strictly greater score takes the lead, so equal scores
          // keep the lower class index. Either way, second never exceeds
          // best, which keeps the margin non-negative.
          if (r_cls == '0 || w_score > r_best) begin
            r_second <= (r_cls == '0) ? '0 : r_best;
            r_best   <= w_score;
            r_idx    <= r_cls;
          end else if (w_score > r_second) begin
            r_second <= w_score;
          end
          r_cls <= (r_cls == LAST_CLS) ? '0 : r_cls + 1'b1;
        end
        default: ; // S_DONE holds everything until the result is taken
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from registers and forced to zero outside DONE
  // ---------------------------------------------------------------------------
  assign in_ready   = w_in_ready;
  assign out_valid  = (r_state == S_DONE);
  assign out_class  = out_valid ? r_idx : '0;
  assign out_score  = out_valid ? r_best : '0;
  assign out_margin = out_valid ? (r_best - r_second) : '0;
  assign out_tie    = out_valid && (r_best == r_second);

endmodule
